// File: rtl/ctrl_pipeline.sv
// Control-path pipeline registers (ID/EX, EX/MEM, MEM/WB) with load-use stall,
// branch/jump squash and EX operand forwarding selects.

package ctrl_pipeline_pkg;

  typedef enum logic [2:0] {
    BR_NOP, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
  } comp_op_t;

  typedef enum logic [1:0] {
    WRSRC_ALURES, WRSRC_MEMREAD, WRSRC_PCINC
  } reg_wr_src_t;

  typedef enum logic [1:0] {
    SRC1_REG1, SRC1_PC, SRC1_ZERO
  } alu_src1_t;

  typedef enum logic [1:0] {
    SRC2_REG2, SRC2_IMM, SRC2_FOUR
  } alu_src2_t;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
    ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI
  } alu_op_t;

endpackage

module ctrl_pipeline
  import ctrl_pipeline_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              id_valid,
  input  logic              id_reg_do_write,
  input  logic              id_mem_do_write,
  input  logic              id_mem_read,
  input  logic              id_do_branch,
  input  logic              id_do_jump,
  input  comp_op_t          id_comp_ctrl,
  input  reg_wr_src_t       id_reg_wr_src,
  input  alu_src1_t         id_alu_op1,
  input  alu_src2_t         id_alu_op2,
  input  alu_op_t           id_alu_ctrl,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,

  input  logic              ex_take_branch,

  output logic              ex_valid,
  output logic              ex_do_branch,
  output logic              ex_do_jump,
  output comp_op_t          ex_comp_ctrl,
  output alu_src1_t         ex_alu_op1,
  output alu_src2_t         ex_alu_op2,
  output alu_op_t           ex_alu_ctrl,
  output logic [REG_AW-1:0] ex_rd,

  output logic              mem_valid,
  output logic              mem_reg_do_write,
  output logic              mem_mem_do_write,
  output logic              mem_mem_read,
  output reg_wr_src_t       mem_reg_wr_src,
  output logic [REG_AW-1:0] mem_rd,

  output logic              wb_valid,
  output logic              wb_reg_do_write,
  output reg_wr_src_t       wb_reg_wr_src,
  output logic [REG_AW-1:0] wb_rd,

  output logic              stall_fetch,
  output logic              flush_if_id,
  output logic              pc_redirect,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  typedef struct packed {
    logic              valid;
    logic              reg_do_write;
    logic              mem_do_write;
    logic              mem_read;
    logic              do_branch;
    logic              do_jump;
    comp_op_t          comp_ctrl;
    reg_wr_src_t       reg_wr_src;
    alu_src1_t         alu_op1;
    alu_src2_t         alu_op2;
    alu_op_t           alu_ctrl;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } ex_stage_t;

  typedef struct packed {
    logic              valid;
    logic              reg_do_write;
    logic              mem_do_write;
    logic              mem_read;
    reg_wr_src_t       reg_wr_src;
    logic [REG_AW-1:0] rd;
  } mem_stage_t;

  typedef struct packed {
    logic              valid;
    logic              reg_do_write;
    reg_wr_src_t       reg_wr_src;
    logic [REG_AW-1:0] rd;
  } wb_stage_t;

  localparam ex_stage_t ExBubble = '{
    valid:        1'b0,
    reg_do_write: 1'b0,
    mem_do_write: 1'b0,
    mem_read:     1'b0,
    do_branch:    1'b0,
    do_jump:      1'b0,
    comp_ctrl:    BR_NOP,
    reg_wr_src:   WRSRC_ALURES,
    alu_op1:      SRC1_REG1,
    alu_op2:      SRC2_REG2,
    alu_ctrl:     ALU_NOP,
    rs1:          '0,
    rs2:          '0,
    rd:           '0
  };

  localparam mem_stage_t MemBubble = '{
    valid:        1'b0,
    reg_do_write: 1'b0,
    mem_do_write: 1'b0,
    mem_read:     1'b0,
    reg_wr_src:   WRSRC_ALURES,
    rd:           '0
  };

  localparam wb_stage_t WbBubble = '{
    valid:        1'b0,
    reg_do_write: 1'b0,
    reg_wr_src:   WRSRC_ALURES,
    rd:           '0
  };

  ex_stage_t  ex_q,  ex_d;
  mem_stage_t mem_q, mem_d;
  wb_stage_t  wb_q,  wb_d;

  logic flush;
  logic load_use;

  // Hazard detection works on the instruction currently in EX.
  always_comb begin
    flush    = ex_q.valid & ((ex_q.do_branch & ex_take_branch) | ex_q.do_jump);
    load_use = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
               ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
  end

  always_comb begin
    ex_d = ExBubble;
    if (!(flush || load_use || !id_valid)) begin
      ex_d.valid        = 1'b1;
      ex_d.reg_do_write = id_reg_do_write;
      ex_d.mem_do_write = id_mem_do_write;
      ex_d.mem_read     = id_mem_read;
      ex_d.do_branch    = id_do_branch;
      ex_d.do_jump      = id_do_jump;
      ex_d.comp_ctrl    = id_comp_ctrl;
      ex_d.reg_wr_src   = id_reg_wr_src;
      ex_d.alu_op1      = id_alu_op1;
      ex_d.alu_op2      = id_alu_op2;
      ex_d.alu_ctrl     = id_alu_ctrl;
      ex_d.rs1          = id_rs1;
      ex_d.rs2          = id_rs2;
      ex_d.rd           = id_rd;
    end
  end

  always_comb begin
    mem_d = '{
      valid:        ex_q.valid,
      reg_do_write: ex_q.reg_do_write,
      mem_do_write: ex_q.mem_do_write,
      mem_read:     ex_q.mem_read,
      reg_wr_src:   ex_q.reg_wr_src,
      rd:           ex_q.rd
    };
    wb_d = '{
      valid:        mem_q.valid,
      reg_do_write: mem_q.reg_do_write,
      reg_wr_src:   mem_q.reg_wr_src,
      rd:           mem_q.rd
    };
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= ExBubble;
      mem_q <= MemBubble;
      wb_q  <= WbBubble;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // MEM is the younger producer, so it wins over WB.
  logic mem_fwd_ok, wb_fwd_ok;

  always_comb begin
    mem_fwd_ok = mem_q.valid & mem_q.reg_do_write & (mem_q.rd != '0);
    wb_fwd_ok  = wb_q.valid & wb_q.reg_do_write & (wb_q.rd != '0);

    fwd_a = 2'b00;
    if (mem_fwd_ok && (mem_q.rd == ex_q.rs1)) begin
      fwd_a = 2'b01;
    end else if (wb_fwd_ok && (wb_q.rd == ex_q.rs1)) begin
      fwd_a = 2'b10;
    end

    fwd_b = 2'b00;
    if (mem_fwd_ok && (mem_q.rd == ex_q.rs2)) begin
      fwd_b = 2'b01;
    end else if (wb_fwd_ok && (wb_q.rd == ex_q.rs2)) begin
      fwd_b = 2'b10;
    end
  end

  always_comb begin
    stall_fetch = load_use & ~flush;
    flush_if_id = flush;
    pc_redirect = flush;
  end

  assign ex_valid         = ex_q.valid;
  assign ex_do_branch     = ex_q.do_branch;
  assign ex_do_jump       = ex_q.do_jump;
  assign ex_comp_ctrl     = ex_q.comp_ctrl;
  assign ex_alu_op1       = ex_q.alu_op1;
  assign ex_alu_op2       = ex_q.alu_op2;
  assign ex_alu_ctrl      = ex_q.alu_ctrl;
  assign ex_rd            = ex_q.rd;

  assign mem_valid        = mem_q.valid;
  assign mem_reg_do_write = mem_q.reg_do_write;
  assign mem_mem_do_write = mem_q.mem_do_write;
  assign mem_mem_read     = mem_q.mem_read;
  assign mem_reg_wr_src   = mem_q.reg_wr_src;
  assign mem_rd           = mem_q.rd;

  assign wb_valid         = wb_q.valid;
  assign wb_reg_do_write  = wb_q.reg_do_write;
  assign wb_reg_wr_src    = wb_q.reg_wr_src;
  assign wb_rd            = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboard bench for ctrl_pipeline: expectations are queued with the cycle they
// apply to when stimulus is driven, and checked on the falling edge of that cycle.

module tb_ctrl_pipeline;
  import ctrl_pipeline_pkg::*;

  localparam int unsigned REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid, id_reg_do_write, id_mem_do_write, id_mem_read;
  logic              id_do_branch, id_do_jump;
  comp_op_t          id_comp_ctrl;
  reg_wr_src_t       id_reg_wr_src;
  alu_src1_t         id_alu_op1;
  alu_src2_t         id_alu_op2;
  alu_op_t           id_alu_ctrl;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              ex_take_branch;

  logic              ex_valid, ex_do_branch, ex_do_jump;
  comp_op_t          ex_comp_ctrl;
  alu_src1_t         ex_alu_op1;
  alu_src2_t         ex_alu_op2;
  alu_op_t           ex_alu_ctrl;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_valid, mem_reg_do_write, mem_mem_do_write, mem_mem_read;
  reg_wr_src_t       mem_reg_wr_src;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_valid, wb_reg_do_write;
  reg_wr_src_t       wb_reg_wr_src;
  logic [REG_AW-1:0] wb_rd;
  logic              stall_fetch, flush_if_id, pc_redirect;
  logic [1:0]        fwd_a, fwd_b;

  ctrl_pipeline #(.REG_AW(REG_AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_reg_do_write  (id_reg_do_write),
    .id_mem_do_write  (id_mem_do_write),
    .id_mem_read      (id_mem_read),
    .id_do_branch     (id_do_branch),
    .id_do_jump       (id_do_jump),
    .id_comp_ctrl     (id_comp_ctrl),
    .id_reg_wr_src    (id_reg_wr_src),
    .id_alu_op1       (id_alu_op1),
    .id_alu_op2       (id_alu_op2),
    .id_alu_ctrl      (id_alu_ctrl),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_rd            (id_rd),
    .ex_take_branch   (ex_take_branch),
    .ex_valid         (ex_valid),
    .ex_do_branch     (ex_do_branch),
    .ex_do_jump       (ex_do_jump),
    .ex_comp_ctrl     (ex_comp_ctrl),
    .ex_alu_op1       (ex_alu_op1),
    .ex_alu_op2       (ex_alu_op2),
    .ex_alu_ctrl      (ex_alu_ctrl),
    .ex_rd            (ex_rd),
    .mem_valid        (mem_valid),
    .mem_reg_do_write (mem_reg_do_write),
    .mem_mem_do_write (mem_mem_do_write),
    .mem_mem_read     (mem_mem_read),
    .mem_reg_wr_src   (mem_reg_wr_src),
    .mem_rd           (mem_rd),
    .wb_valid         (wb_valid),
    .wb_reg_do_write  (wb_reg_do_write),
    .wb_reg_wr_src    (wb_reg_wr_src),
    .wb_rd            (wb_rd),
    .stall_fetch      (stall_fetch),
    .flush_if_id      (flush_if_id),
    .pc_redirect      (pc_redirect),
    .fwd_a            (fwd_a),
    .fwd_b            (fwd_b)
  );

  always #5 clk = ~clk;

  typedef enum int {
    P_EXV, P_MEMV, P_WBV, P_EXALU, P_EXRD, P_MEMRD, P_WBRD,
    P_FWDA, P_FWDB, P_STALL, P_FLUSH, P_REDIR
  } probe_e;

  typedef enum int { I_ADD, I_LW, I_BEQ, I_JAL, I_LWJ } instr_e;

  typedef struct {
    int     cyc;
    string  tag;
    probe_e p;
    int     val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] probe(input probe_e p);
    case (p)
      P_EXV:   return 32'(ex_valid);
      P_MEMV:  return 32'(mem_valid);
      P_WBV:   return 32'(wb_valid);
      P_EXALU: return 32'(ex_alu_ctrl);
      P_EXRD:  return 32'(ex_rd);
      P_MEMRD: return 32'(mem_rd);
      P_WBRD:  return 32'(wb_rd);
      P_FWDA:  return 32'(fwd_a);
      P_FWDB:  return 32'(fwd_b);
      P_STALL: return 32'(stall_fetch);
      P_FLUSH: return 32'(flush_if_id);
      P_REDIR: return 32'(pc_redirect);
      default: return 32'hdead_beef;
    endcase
  endfunction

  // Keep the queue ordered by target cycle.
  task automatic expect_at(input int dc, input string tag, input probe_e p, input int val);
    exp_t e;
    int   pos;
    e.cyc = cyc + dc;
    e.tag = tag;
    e.p   = p;
    e.val = val;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > e.cyc) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) check({e.tag, "_missed"}, 32'(cyc), 32'(e.cyc));
      else             check(e.tag, probe(e.p), 32'(e.val));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid        = 1'b0;
    id_reg_do_write = 1'b0;
    id_mem_do_write = 1'b0;
    id_mem_read     = 1'b0;
    id_do_branch    = 1'b0;
    id_do_jump      = 1'b0;
    id_comp_ctrl    = BR_NOP;
    id_reg_wr_src   = WRSRC_ALURES;
    id_alu_op1      = SRC1_REG1;
    id_alu_op2      = SRC2_REG2;
    id_alu_ctrl     = ALU_NOP;
    id_rs1          = '0;
    id_rs2          = '0;
    id_rd           = '0;
  endtask

  // I_LWJ is a synthetic bundle (load + jump) so a flush and a load-use hit coincide.
  task automatic set_id(input instr_e k, input int rd, input int rs1, input int rs2);
    clear_id();
    id_valid    = 1'b1;
    id_rd       = REG_AW'(rd);
    id_rs1      = REG_AW'(rs1);
    id_rs2      = REG_AW'(rs2);
    id_alu_ctrl = ALU_ADD;
    case (k)
      I_ADD: id_reg_do_write = 1'b1;
      I_LW: begin
        id_reg_do_write = 1'b1;
        id_mem_read     = 1'b1;
        id_reg_wr_src   = WRSRC_MEMREAD;
        id_alu_op2      = SRC2_IMM;
      end
      I_BEQ: begin
        id_do_branch = 1'b1;
        id_comp_ctrl = BR_EQ;
        id_alu_op1   = SRC1_PC;
        id_alu_op2   = SRC2_IMM;
      end
      I_JAL: begin
        id_reg_do_write = 1'b1;
        id_do_jump      = 1'b1;
        id_reg_wr_src   = WRSRC_PCINC;
        id_alu_op1      = SRC1_PC;
        id_alu_op2      = SRC2_IMM;
      end
      I_LWJ: begin
        id_reg_do_write = 1'b1;
        id_mem_read     = 1'b1;
        id_do_jump      = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic idle(input int n);
    clear_id();
    repeat (n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ex_take_branch = 1'b0;
    set_id(I_ADD, 1, 2, 3);
    step();
    step();

    rst = 1'b0;
    clear_id();
    expect_at(0, "rst_exv",   P_EXV,   0);
    expect_at(0, "rst_memv",  P_MEMV,  0);
    expect_at(0, "rst_wbv",   P_WBV,   0);
    expect_at(0, "rst_alu",   P_EXALU, int'(ALU_NOP));
    expect_at(0, "rst_fwda",  P_FWDA,  0);
    expect_at(0, "rst_fwdb",  P_FWDB,  0);
    expect_at(0, "rst_stall", P_STALL, 0);
    expect_at(0, "rst_redir", P_REDIR, 0);
    step();

    // Forward chain.
    set_id(I_ADD, 5, 1, 2);
    step();
    set_id(I_ADD, 6, 5, 5);
    expect_at(1, "fc_fwda_mem", P_FWDA, 1);
    expect_at(1, "fc_fwdb_mem", P_FWDB, 1);
    step();
    set_id(I_ADD, 7, 5, 1);
    expect_at(1, "fc_fwda_wb", P_FWDA, 2);
    expect_at(1, "fc_fwdb_rf", P_FWDB, 0);
    expect_at(1, "fc_exrd",    P_EXRD, 7);
    expect_at(1, "fc_wbrd",    P_WBRD, 5);
    step();
    idle(3);

    // Load-use: one-cycle stall, ADD held in ID by the bench.
    set_id(I_LW, 3, 1, 0);
    step();
    set_id(I_ADD, 4, 3, 2);
    expect_at(0, "lu_stall",   P_STALL, 1);
    expect_at(0, "lu_noflush", P_FLUSH, 0);
    step();
    expect_at(0, "lu_bubble",     P_EXV,   0);
    expect_at(0, "lu_stall_once", P_STALL, 0);
    expect_at(0, "lu_memrd",      P_MEMRD, 3);
    step();
    clear_id();
    expect_at(0, "lu_exv",  P_EXV,  1);
    expect_at(0, "lu_fwda", P_FWDA, 2);
    expect_at(0, "lu_fwdb", P_FWDB, 0);
    idle(3);

    // Back-to-back independent loads.
    set_id(I_LW, 12, 1, 0);
    step();
    set_id(I_LW, 13, 2, 0);
    expect_at(0, "ll_nostall", P_STALL, 0);
    step();
    clear_id();
    expect_at(0, "ll_exv",  P_EXV,  1);
    expect_at(0, "ll_exrd", P_EXRD, 13);
    idle(3);

    // Taken branch.
    set_id(I_BEQ, 0, 1, 2);
    step();
    ex_take_branch = 1'b1;
    set_id(I_ADD, 8, 1, 1);
    expect_at(0, "br_redir",   P_REDIR, 1);
    expect_at(0, "br_flush",   P_FLUSH, 1);
    expect_at(0, "br_nostall", P_STALL, 0);
    step();
    ex_take_branch = 1'b0;
    clear_id();
    expect_at(0, "br_bubble",     P_EXV,   0);
    expect_at(0, "br_redir_once", P_REDIR, 0);
    idle(2);

    // Not-taken branch.
    set_id(I_BEQ, 0, 1, 2);
    step();
    set_id(I_ADD, 9, 1, 1);
    expect_at(0, "bn_redir", P_REDIR, 0);
    expect_at(0, "bn_flush", P_FLUSH, 0);
    step();
    clear_id();
    expect_at(0, "bn_exv",  P_EXV,  1);
    expect_at(0, "bn_exrd", P_EXRD, 9);
    idle(3);

    // Plain JAL redirects.
    set_id(I_JAL, 1, 0, 0);
    step();
    clear_id();
    expect_at(0, "jal_redir", P_REDIR, 1);
    idle(3);

    // Flush beats load-use stall.
    set_id(I_LWJ, 3, 1, 0);
    step();
    set_id(I_ADD, 4, 3, 3);
    expect_at(0, "jl_stall", P_STALL, 0);
    expect_at(0, "jl_flush", P_FLUSH, 1);
    step();
    clear_id();
    expect_at(0, "jl_bubble", P_EXV, 0);
    idle(3);

    // x0 gating for both load-use and forwarding.
    set_id(I_LW, 0, 1, 0);
    step();
    set_id(I_ADD, 1, 0, 0);
    expect_at(0, "x0_nostall", P_STALL, 0);
    step();
    set_id(I_ADD, 0, 1, 2);
    expect_at(0, "x0_exv", P_EXV, 1);
    step();
    set_id(I_ADD, 10, 0, 0);
    step();
    set_id(I_ADD, 11, 0, 0);
    expect_at(0, "x0_mem_fwda", P_FWDA, 0);
    expect_at(0, "x0_mem_fwdb", P_FWDB, 0);
    step();
    clear_id();
    expect_at(0, "x0_wb_fwda", P_FWDA, 0);
    expect_at(0, "x0_wb_fwdb", P_FWDB, 0);
    idle(3);

    // Mid-operation reset.
    set_id(I_ADD, 20, 1, 2);
    step();
    set_id(I_ADD, 21, 1, 2);
    step();
    set_id(I_ADD, 22, 1, 2);
    rst = 1'b1;
    expect_at(0, "mr_memv_pre", P_MEMV, 1);
    step();
    rst = 1'b0;
    clear_id();
    expect_at(0, "mr_exv",  P_EXV,  0);
    expect_at(0, "mr_memv", P_MEMV, 0);
    expect_at(0, "mr_wbv",  P_WBV,  0);
    idle(3);

    if (sb.size() != 0) check("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
